// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered immediate generator between fetch and decode/execute. Decodes
//   the instruction format on the input side and registers the XLEN-wide
//   immediate, format code and illegal flag alongside inst and pc. A 2-entry
//   skid (output register + skid register) absorbs back-pressure so that
//   in_ready can be a registered output.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             synchronous flush, drops every buffered entry
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_inst, in_pc    instruction word and PC
//   out_valid/out_ready downstream handshake
//   out_inst, out_pc  passthrough
//   out_imm           sign/zero-extended immediate
//   out_fmt           0 NONE,1 I,2 I_SHIFT,3 S,4 B,5 U,6 J,7 CSR_Z
//   out_illegal       unknown opcode or in_inst[1:0] != 2'b11
module imm_gen_pipe #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_ISH = 3'd2, F_S = 3'd3,
                           F_B = 3'd4, F_U = 3'd5, F_J = 3'd6, F_CSRZ = 3'd7;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    state_t state;
    entry_t dec, out_r, skid_r;

    logic [6:0] opc;
    logic [2:0] funct3;
    assign opc    = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // Format decode; sign extension comes from casting a signed value up to XLEN.
    always_comb begin
        dec         = '0;
        dec.inst    = in_inst;
        dec.pc      = in_pc;
        case (opc)
            7'b0000011, 7'b1100111: begin
                dec.fmt = F_I;
                dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Only the shamt field forms the immediate; funct7 (SRAI bit) is ignored.
                    dec.fmt = F_ISH;
                    dec.imm = XLEN'(in_inst[20 +: SHAMT_W]);
                    if (XLEN == 32 && in_inst[25]) dec.illegal = 1'b1;
                end else begin
                    dec.fmt = F_I;
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0100011: begin
                dec.fmt = F_S;
                dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = F_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = F_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec.fmt = F_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            7'b1110011: begin
                if (funct3[2]) begin
                    dec.fmt = F_CSRZ;
                    dec.imm = XLEN'(in_inst[19:15]);
                end else begin
                    dec.fmt = F_I;
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0110011, 7'b0001111: dec.fmt = F_NONE;
            default:                dec.illegal = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) dec.illegal = 1'b1;
    end

    logic accept, drain;
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Skid FSM. in_ready is registered as "next state is not TWO", so there is
    // no combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_r     <= '0;
            skid_r    <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    out_r     <= dec;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: begin
                    if (accept && drain) begin
                        out_r <= dec;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept) begin
                        skid_r   <= dec;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end
                end
                TWO: if (drain) begin
                    out_r    <= skid_r;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_inst    = out_r.inst;
    assign out_pc      = out_r.pc;
    assign out_imm     = out_r.imm;
    assign out_fmt     = out_r.fmt;
    assign out_illegal = out_r.illegal;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the next-generation pipelined core. It sits between fetch and decode/execute.
- Takes an instruction word and PC over a valid/ready handshake, decodes the format, and produces the XLEN-wide sign- or zero-extended immediate, a format code and an illegal flag.
- Uses a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Supports every RV32I/RV64I immediate format, including CSR zimm.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64. Immediates are extended to XLEN.
- SHAMT_W, $clog2(XLEN), shift-amount width (5 for RV32, 6 for RV64). Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush; kills all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept; registered, equals !(skid entry valid)
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  instruction passthrough
- out_pc  out  XLEN  PC passthrough
- out_imm  out  XLEN  generated immediate
- out_fmt  out  3  0=NONE, 1=I, 2=I_SHIFT, 3=S, 4=B, 5=U, 6=J, 7=CSR_Z
- out_illegal  out  1  unknown opcode, or in_inst[1:0] != 2'b11

Behaviour:
- Reset: out_valid=0, in_ready=1, and out_inst, out_pc, out_imm, out_fmt, out_illegal all 0. The skid entry is invalid.
- Handshake and latency:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - Latency is 1 cycle: an accepted instruction appears on out_* the next cycle when the output register is empty or draining.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Decode is combinational on the input side; results are registered together with inst and pc. Formats by opcode:
  - 0000011 (load), 1100111 (JALR), 0010011 (OP-IMM non-shift): I-type. imm = sext(inst[31:20]).
  - 0010011 with funct3 001 or 101: I_SHIFT. imm = zext(inst[20+SHAMT_W-1:20]).
    - For XLEN=32, inst[25]=1 sets illegal.
    - funct7 bits above the shamt (inst[30] distinguishes SRAI) are ignored for the immediate.
  - 0100011: S. imm = sext({inst[31:25], inst[11:7]}).
  - 1100011: B. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 / 0010111: U. imm = sext({inst[31:12], 12'b0}); sign extension applies for XLEN=64.
  - 1101111: J. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 1110011: if funct3[2]=1, CSR_Z with imm = zext(inst[19:15]); else I-type.
  - 0110011, 0001111: NONE, imm=0.
  - Any other opcode: NONE, imm=0, illegal=1.
- Skid FSM. States EMPTY (out invalid), ONE (out valid, skid empty), TWO (out valid, skid full).
  - EMPTY: an accept goes to ONE.
  - ONE:
    - accept and drain: stay in ONE; the output reloads with the new entry.
    - drain only: go to EMPTY.
    - accept without drain: go to TWO; the new entry goes into the skid.
  - TWO: in_ready=0.
    - drain: go to ONE; the skid moves to output.
    - no drain: hold.
- flush: has priority over everything else in the same cycle. Next state is EMPTY and in_ready=1; any concurrent input is dropped. flush with reset asserted behaves as reset.
- Reset mid-operation discards both entries. There is no partial output.
- in_ready is a registered output; no combinational path from out_ready to in_ready.
- in_* are sampled only when in_valid && in_ready. Values of in_* while in_valid=0 have no effect.

Test Plan:
- Reset, then feed 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt=4; 0xFF9FF06F (jal -8) -> imm 0xFFFFFFF8, fmt=6.
- 0x123452B7 (lui x5,0x12345) -> imm 0x12345000, fmt=5; XLEN=64 build with 0x800002B7 -> imm 0xFFFFFFFF80000000.
- 0x4030D093 (srai x1,x1,3) -> imm 0x00000003, fmt=2; 0xFE002FA3 (sw -1) -> imm 0xFFFFFFFF, fmt=3; 0x00000000 -> illegal=1.
- Back-pressure: out_ready=0, send three back-to-back instructions A,B,C -> A held on output, B in skid, in_ready=0 the cycle after B, C waits. Raise out_ready -> A, B, C delivered in order, no loss or duplication.
- State TWO plus flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed entries and the concurrent input never appear.
